load_use_scoreboard: RTL

// Parametrised load-use hazard unit for the multi-issue integer pipeline, sitting between decode and EX.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/sb_countdown.sv | 22 ++
 rtl/load_use_scoreboard.sv | 101 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions: register file geometry and load ALU codes.
package riscv_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NREG_DEFAULT = 32;

  // Load operation codes as produced by decode; dec_is_load is derived from these.
  localparam logic [4:0] ALU_LB  = 5'h10;
  localparam logic [4:0] ALU_LH  = 5'h11;
  localparam logic [4:0] ALU_LW  = 5'h12;
  localparam logic [4:0] ALU_LBU = 5'h14;
  localparam logic [4:0] ALU_LHU = 5'h15;

  function automatic logic is_load_op(input logic [4:0] op);
    return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
           (op == ALU_LBU) || (op == ALU_LHU);
  endfunction

endpackage

// File: rtl/sb_countdown.sv
// One scoreboard entry: countdown of remaining cycles until a load result is forwardable.
module sb_countdown #(
  parameter int W   = 1,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         set,
  output logic [W-1:0] cnt,
  output logic         pending
);

  // A new load reloads the full latency; otherwise count down toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (set)        cnt <= W'(LAT);
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign pending = (cnt != '0);

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit: per-register load countdowns, intra-bundle RAW checks,
// in-order stall chain, issue mask and a saturating stall-cycle counter.
module load_use_scoreboard
  import riscv_pkg::*;
#(
  parameter int ISSUE_W  = 2,
  parameter int NREG     = NREG_DEFAULT,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [ISSUE_W-1:0]           dec_valid,
  input  logic [ISSUE_W-1:0]           dec_is_load,
  input  logic [ISSUE_W-1:0]           dec_we,
  input  logic [ISSUE_W*REG_ADDR_W-1:0] dec_rd,
  input  logic [ISSUE_W*REG_ADDR_W-1:0] dec_rs1,
  input  logic [ISSUE_W*REG_ADDR_W-1:0] dec_rs2,
  output logic [ISSUE_W-1:0]           stall,
  output logic [ISSUE_W-1:0]           issue,
  output logic                         stall_any,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int SB_W   = $clog2(LOAD_LAT + 1);
  localparam int RSPACE = 2 ** REG_ADDR_W;

  logic [ISSUE_W-1:0][REG_ADDR_W-1:0] rd_l, rs1_l, rs2_l;
  logic [RSPACE-1:0]                  pend;
  logic [ISSUE_W-1:0]                 haz, chain;
  logic                               active;

  assign rd_l  = dec_rd;
  assign rs1_l = dec_rs1;
  assign rs2_l = dec_rs2;

  // Nothing is stalled or issued while the bundle is being killed or the unit is in reset.
  assign active = rst_n & ~flush;

  // Scoreboard: x0 and addresses beyond NREG are never pending.
  for (genvar r = 0; r < RSPACE; r++) begin : g_reg
    if (r == 0 || r >= NREG) begin : g_none
      assign pend[r] = 1'b0;
    end else begin : g_sb
      logic [ISSUE_W-1:0] hit;
      logic [SB_W-1:0]    cnt;
      logic               set;
      for (genvar k = 0; k < ISSUE_W; k++) begin : g_hit
        assign hit[k] = (rd_l[k] == REG_ADDR_W'(r));
      end
      // Several lanes loading the same rd simply set it once.
      assign set = |(issue & dec_is_load & hit);
      sb_countdown #(.W(SB_W), .LAT(LOAD_LAT)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (set),
        .cnt     (cnt),
        .pending (pend[r])
      );
    end
  end

  // Per-lane hazard detection and in-order stall chain.
  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    logic intra;
    logic sb_haz;

    // RAW on any write by an older valid lane of the same bundle (no forwarding).
    always_comb begin
      intra = 1'b0;
      for (int i = 0; i < k; i++)
        if (dec_valid[i] && dec_we[i] && rd_l[i] != '0 &&
            (rd_l[i] == rs1_l[k] || rd_l[i] == rs2_l[k]))
          intra = 1'b1;
    end

    assign sb_haz = (rs1_l[k] != '0 && pend[rs1_l[k]]) ||
                    (rs2_l[k] != '0 && pend[rs2_l[k]]);
    assign haz[k] = sb_haz | intra;

    if (k == 0) begin : g_first
      assign chain[k] = haz[k] & dec_valid[k];
    end else begin : g_rest
      assign chain[k] = (haz[k] & dec_valid[k]) | chain[k-1];
    end
  end

  assign stall     = chain & {ISSUE_W{active}};
  assign issue     = dec_valid & ~chain & {ISSUE_W{active}};
  assign stall_any = |stall;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall_any && !flush && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
